tree_traverse_engine: RTL and testbench

- Walks one decision tree stored in a registered-read node ROM (120-bit node words, 1-cycle read latency) from root to leaf for one latched feature vector.
- Drives the ROM address, decodes each returned node, compares the selected feature against the node's IEEE-754 double threshold, follows the left or right child, and returns the leaf class.
- Sits between the feature-vector loader (upstream) and the vote/ensemble stage (downstream); one instance per tree ROM.

---
 rtl/tree_pkg.sv | 37 +++
 rtl/fp64_le_cmp.sv | 41 ++++
 rtl/tree_traverse_engine.sv | 162 ++++++++++++++++
 tb/tb_tree_traverse_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tree_pkg : node layout, leaf marker and FSM states for the tree engines
// Revision : 1.0
// ---------------------------------------------------------------------------
package tree_pkg;

  localparam int FP64_W        = 64;
  localparam int NODE_FIELDS_W = 108;

  localparam int NODE_ID_LSB    = 96;
  localparam int NODE_FEAT_LSB  = 92;
  localparam int NODE_THR_LSB   = 28;
  localparam int NODE_LEFT_LSB  = 16;
  localparam int NODE_RIGHT_LSB = 4;
  localparam int NODE_TAG_LSB   = 0;

  localparam logic [3:0] LEAF_MARK = 4'h3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [11:0]       id;
    logic [3:0]        feat;
    logic [FP64_W-1:0] thr;
    logic [11:0]       left;
    logic [11:0]       right;
    logic [3:0]        tag;
  } node_t;

endpackage
`default_nettype wire

// File: rtl/fp64_le_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp64_le_cmp : combinational IEEE-754 double a <= b; NaN gives 0, +0 == -0
// Revision    : 1.0
// ---------------------------------------------------------------------------
module fp64_le_cmp
  import tree_pkg::*;
(
  input  logic [FP64_W-1:0] a,
  input  logic [FP64_W-1:0] b,
  output logic              le
);

  logic              a_nan;
  logic              b_nan;
  logic [FP64_W-2:0] a_mag;
  logic [FP64_W-2:0] b_mag;

  assign a_mag = a[FP64_W-2:0];
  assign b_mag = b[FP64_W-2:0];
  assign a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != '0);
  assign b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != '0);

  // Sign-magnitude ordering; negative operands reverse the magnitude test.
  always_comb begin
    le = 1'b0;
    if (a_nan || b_nan) begin
      le = 1'b0;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      le = 1'b1;
    end else if (a[FP64_W-1] != b[FP64_W-1]) begin
      le = a[FP64_W-1];
    end else if (!a[FP64_W-1]) begin
      le = (a_mag <= b_mag);
    end else begin
      le = (a_mag >= b_mag);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tree_traverse_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tree_traverse_engine : walks one decision-tree ROM from root to leaf
// Optional out_depth port under TREE_TRAVERSE_DEPTH_OUT_EN. Revision : 1.0
// ---------------------------------------------------------------------------
module tree_traverse_engine
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_FEATURES = 16,
  parameter int MAX_DEPTH    = 32,
  parameter int CLASS_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_FEATURES*FP64_W-1:0] feat_vec,
  output logic [ADDR_WIDTH-1:0]          rom_addr,
  input  logic [NODE_WIDTH-1:0]          rom_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLASS_WIDTH-1:0]         out_class,
  output logic                           out_err
`ifdef TREE_TRAVERSE_DEPTH_OUT_EN
  ,
  output logic [5:0]                     out_depth
`endif
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  state_e                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            ptr_q, ptr_d;
  logic [DEPTH_W-1:0]               depth_q, depth_d;
  logic [NUM_FEATURES*FP64_W-1:0]   feat_q, feat_d;
  logic [CLASS_WIDTH-1:0]           class_q, class_d;
  logic                             err_q, err_d;

  node_t             node_w;
  logic [FP64_W-1:0] x_w;
  logic              le_w;
  logic [11:0]       child_w;
  logic              id_ok_w;
  logic              is_leaf_w;
  logic              feat_bad_w;
  logic              child_bad_w;
  logic              depth_hit_w;
  logic              unused_w;

  assign node_w   = node_t'(rom_data[NODE_FIELDS_W-1:0]);
  assign unused_w = ^rom_data[NODE_WIDTH-1:NODE_FIELDS_W];

  always_comb begin
    x_w = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (int'(node_w.feat) == i) x_w = feat_q[FP64_W*i +: FP64_W];
    end
  end

  fp64_le_cmp u_cmp (
    .a  (x_w),
    .b  (node_w.thr),
    .le (le_w)
  );

  assign child_w     = le_w ? node_w.left : node_w.right;
  assign id_ok_w     = (int'(node_w.id) == int'(ptr_q));
  assign is_leaf_w   = (node_w.feat == LEAF_MARK);
  assign feat_bad_w  = (int'(node_w.feat) >= NUM_FEATURES);
  assign child_bad_w = (int'(child_w) >= (1 << ADDR_WIDTH));
  assign depth_hit_w = (int'(depth_q) == MAX_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      depth_q <= '0;
      feat_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      feat_q  <= feat_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    feat_d  = feat_q;
    class_d = class_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          feat_d  = feat_vec;
          ptr_d   = '0;
          depth_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        depth_d = depth_q + 1'b1;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        // Any fault lands in DONE with a cleared class and err set.
        if (!id_ok_w) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (is_leaf_w) begin
          class_d = node_w.tag[CLASS_WIDTH-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (feat_bad_w || child_bad_w || depth_hit_w) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ptr_d   = child_w[ADDR_WIDTH-1:0];
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    rom_addr  = ptr_q;
    out_class = class_q;
    out_err   = err_q;
  end

`ifdef TREE_TRAVERSE_DEPTH_OUT_EN
  logic [5:0] depth_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_out_q <= '0;
    end else if ((state_q == S_EVAL) && (state_d == S_DONE)) begin
      depth_out_q <= 6'(depth_q);
    end
  end

  assign out_depth = depth_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tree_traverse_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tree_traverse_engine : directed plus randomized bench with a real-valued
// tree-walk reference model. Revision : 1.0
// ---------------------------------------------------------------------------
module tb_tree_traverse_engine;

  localparam int NW = 120;
  localparam int AW = 10;
  localparam int NF = 16;
  localparam int MD = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NF*64-1:0] feat_vec = '0;
  logic [AW-1:0]   rom_addr;
  logic [NW-1:0]   rom_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   out_class;
  logic            out_err;
`ifdef TREE_TRAVERSE_DEPTH_OUT_EN
  logic [5:0]      out_depth;
`endif

  logic [NW-1:0] rom [1024];
  int            exp_addr[$];
  int            got_addr[$];
  int            last_lat;
  logic [CW-1:0] last_cls;
  logic          last_err;
  int            vectors = 0;
  int            miscompares = 0;

  tree_traverse_engine #(
    .NODE_WIDTH(NW), .ADDR_WIDTH(AW), .NUM_FEATURES(NF), .MAX_DEPTH(MD), .CLASS_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .feat_vec  (feat_vec),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err)
`ifdef TREE_TRAVERSE_DEPTH_OUT_EN
    ,
    .out_depth (out_depth)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk_leaf(input int id, input logic [3:0] tag);
    return {12'($urandom), 12'(id), 4'h3, $urandom, $urandom, 12'($urandom), 12'($urandom), tag};
  endfunction

  function automatic logic [NW-1:0] mk_int(input int id, input logic [3:0] f,
                                          input logic [63:0] thr, input int l, input int r);
    return {12'($urandom), 12'(id), f, thr, 12'(l), 12'(r), 4'($urandom)};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 9))
      0: return 64'h0000000000000000;
      1: return 64'h8000000000000000;
      2: return 64'h3FF0000000000000;
      3: return 64'hBFF0000000000000;
      4: return 64'h7FF0000000000000;
      5: return 64'hFFF0000000000000;
      6: return 64'h7FF8000000000000;
      7: return 64'h4000000000000000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = '0;
  endtask

  // Reference walk: real-valued compare, stop on leaf or on any fault.
  function automatic void model(input logic [NF*64-1:0] fv, output logic [CW-1:0] cls,
                                output logic err, output int k);
    int ptr = 0;
    bit done = 0;
    exp_addr.delete();
    cls = '0; err = 1'b0; k = 0;
    while (!done) begin
      logic [NW-1:0] w;
      int nxt;
      real x, t;
      k++;
      exp_addr.push_back(ptr);
      w = rom[ptr];
      if (int'(w[107:96]) != ptr) begin
        err = 1'b1; done = 1;
      end else if (w[95:92] == 4'h3) begin
        cls = w[CW-1:0]; done = 1;
      end else begin
        x = $bitstoreal(fv[64*int'(w[95:92]) +: 64]);
        t = $bitstoreal(w[91:28]);
        nxt = (x <= t) ? int'(w[27:16]) : int'(w[15:4]);
        if (nxt >= 1024 || k == MD) begin
          err = 1'b1; done = 1;
        end else begin
          ptr = nxt;
        end
      end
    end
  endfunction

  task automatic run_vec(input logic [NF*64-1:0] fv, input int hold, input bit poke);
    logic [CW-1:0] ecls;
    logic          eerr;
    int            ek;
    model(fv, ecls, eerr, ek);
    got_addr.delete();
    last_lat = 0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    feat_vec = fv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    feat_vec = {NF{pick()}};
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (out_valid) begin
        last_lat = c;
        break;
      end
      if (c % 2 == 1) got_addr.push_back(int'(rom_addr));
    end
    if (last_lat == 0) begin
      chk("timeout", 0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    last_cls = out_class;
    last_err = out_err;
    chk("latency", last_lat, 2 * ek + 1);
    chk("class", out_class, ecls);
    chk("err", out_err, eerr);
    chk("in_ready_done", in_ready, 0);
`ifdef TREE_TRAVERSE_DEPTH_OUT_EN
    chk("depth", out_depth, ek);
`endif
    chk("addr_count", got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      chk("addr_seq", got_addr[i], exp_addr[i]);
    if (poke) in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_class", out_class, ecls);
      chk("hold_err", out_err, eerr);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [NF*64-1:0] fv;
    logic [NW-1:0]    lit;
    clear_rom();

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;

    // Root leaf
    lit = 120'h000300000000000000000000001;
    rom[0] = lit;
    run_vec('0, 0, 0);
    chk("root_leaf_lat", last_lat, 3);
    chk("root_leaf_cls", last_cls, 1);
    chk("root_leaf_err", last_err, 0);

    // Threshold equality goes left, one ulp above goes right
    clear_rom();
    lit = 120'h000A43C2154C500000000010CC3;
    rom[0] = lit;
    rom[1] = mk_leaf(1, 4'h9);
    rom[12'h0CC] = mk_leaf(12'h0CC, 4'hC);
    fv = '0;
    fv[64*10 +: 64] = 64'h43C2154C50000000;
    run_vec(fv, 0, 0);
    chk("eq_addr1", got_addr.size() > 1 ? got_addr[1] : -1, 1);
    chk("eq_cls", last_cls, 4'h9);
    fv[64*10 +: 64] = 64'h43C2154C50000001;
    run_vec(fv, 0, 0);
    chk("gt_addr1", got_addr.size() > 1 ? got_addr[1] : -1, 12'h0CC);
    chk("gt_cls", last_cls, 4'hC);

    // NaN feature goes right; -0 against +0 goes left
    clear_rom();
    rom[0] = mk_int(0, 4'h2, 64'h0000000000000000, 5, 6);
    rom[5] = mk_leaf(5, 4'h5);
    rom[6] = mk_leaf(6, 4'h6);
    fv = '0;
    fv[64*2 +: 64] = 64'h7FF8000000000000;
    run_vec(fv, 0, 0);
    chk("nan_right", last_cls, 4'h6);
    fv[64*2 +: 64] = 64'h8000000000000000;
    run_vec(fv, 0, 0);
    chk("negzero_left", last_cls, 4'h5);

    // Cyclic pointer hits the depth limit
    clear_rom();
    rom[0] = mk_int(0, 4'h1, 64'h3FF0000000000000, 1, 1);
    rom[1] = mk_int(1, 4'h1, 64'h3FF0000000000000, 1, 1);
    run_vec(fv, 0, 0);
    chk("cyc_lat", last_lat, 65);
    chk("cyc_err", last_err, 1);
    chk("cyc_cls", last_cls, 0);

    // Back-pressure with in_valid held high during DONE
    clear_rom();
    rom[0] = mk_leaf(0, 4'hA);
    run_vec(fv, 10, 1);

    // Reset during EVAL of the third node of a 5-node chain
    for (int i = 0; i < 4; i++) rom[i] = mk_int(i, 4'h0, 64'h0, i + 1, i + 1);
    rom[4] = mk_leaf(4, 4'h7);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_out_class", out_class, 0);
    chk("midrst_out_err", out_err, 0);
    run_vec(fv, 0, 0);
    chk("postrst_cls", last_cls, 4'h7);
    chk("postrst_lat", last_lat, 11);

    // Randomized trees with occasional ID and child-range faults
    for (int r = 0; r < 4; r++) begin
      clear_rom();
      for (int i = 0; i < 15; i++) begin
        logic [3:0] f;
        int l, rr, id;
        f = 4'($urandom_range(0, 14));
        if (f >= 4'h3) f = f + 4'h1;
        l = 2 * i + 1;
        rr = 2 * i + 2;
        id = i;
        case ($urandom_range(0, 15))
          0: id = i ^ 1;
          1: l = 12'h400 + $urandom_range(0, 255);
          2: rr = 12'hFFF;
          default: ;
        endcase
        rom[i] = mk_int(id, f, pick(), l, rr);
      end
      for (int i = 15; i < 31; i++) rom[i] = mk_leaf(i, 4'($urandom));
      for (int v = 0; v < 12; v++) begin
        for (int j = 0; j < NF; j++) fv[64*j +: 64] = pick();
        run_vec(fv, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
